// File: rtl/spi_master_pkg.sv
// ---------------------------------------------------------------------------
// spi_master_pkg
// Shared constants for the SPI mode-0 initiator: frame geometry, command
// encoding, FSM state codes and the frame-building helper.
// ---------------------------------------------------------------------------
package spi_master_pkg;

  localparam int FRAME_BITS = 16;
  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;

  localparam logic CMD_READ  = 1'b1;
  localparam logic CMD_WRITE = 1'b0;

  // FSM state codes
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  // Command byte {addr, rw} followed by the data byte. A read sends a zero
  // data byte because the slave is driving MISO during that phase.
  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic [ADDR_W-1:0] a,
    input logic              r,
    input logic [DATA_W-1:0] d
  );
    return {a, r, (r == CMD_WRITE) ? d : {DATA_W{1'b0}}};
  endfunction

endpackage

// File: rtl/spi_clkgen.sv
// ---------------------------------------------------------------------------
// spi_clkgen
// Bit-period counter for the SPI shift phase. One SCLK period is 2*CLKDIV
// system clocks. The ticks announce the SCLK edge that the owner should
// register on the coming clock edge.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   en_i       counting enable; the counter is held at zero when low
//   fall_tick  last cycle of the high phase (SCLK falls on the next edge)
//   rise_tick  last cycle of the low phase (SCLK rises on the next edge)
// ---------------------------------------------------------------------------
module spi_clkgen #(
  parameter int CLKDIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int            CW        = $clog2(2 * CLKDIV);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKDIV - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(2 * CLKDIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Count 0 .. 2*CLKDIV-1 within each bit period, wrap, and stay cleared
  // while disabled so every shift phase starts at the beginning of a period.
  always_comb begin
    cnt_d = '0;
    if (en_i && (cnt_q != FULL_LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign fall_tick = en_i && (cnt_q == HALF_LAST);
  assign rise_tick = en_i && (cnt_q == FULL_LAST);

endmodule

// File: rtl/spi_master.sv
// ---------------------------------------------------------------------------
// spi_master
// SPI mode-0, MSB-first initiator issuing single-byte read/write transactions
// as a 16-bit frame {addr[6:0], rw, data[7:0]}.
//
// Parameters:
//   CLKDIV     system clocks per SCLK half-period (minimum 4)
//
// Ports:
//   clk, rst_n           system clock, asynchronous active-low reset
//   start, rw, addr, wdata   request (start sampled only while idle)
//   busy                 transaction in progress, including the CS gap
//   done                 one-cycle pulse at the end of a transaction
//   rdata                last read result
//   sclk_pin, cs_pin, mosi_pin, miso_pin   SPI wires
//
// Build option:
//   SPI_MASTER_MISO_SYNC_EN  route miso_pin through a two-flop synchronizer
// ---------------------------------------------------------------------------
module spi_master
  import spi_master_pkg::*;
#(
  parameter int CLKDIV = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              sclk_pin,
  output logic              cs_pin,
  output logic              mosi_pin,
  input  logic              miso_pin
);

  localparam int            TW       = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(CLKDIV - 1);
  localparam int            BW       = $clog2(FRAME_BITS);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);

  logic [2:0]            state_q, state_d;
  logic [TW-1:0]         tmr_q, tmr_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic                  rw_q, rw_d;
  logic                  sclk_q, sclk_d;
  logic                  cs_q, cs_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  cap_q, cap_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic [DATA_W-1:0]     rshift_q, rshift_d;

  logic [FRAME_BITS-1:0] req_frame;
  logic                  rise_tick, fall_tick;
  logic                  miso_s;
  logic                  tmr_end;

  assign req_frame = build_frame(addr, rw, wdata);
  assign tmr_end   = (tmr_q == TMR_LAST);

  spi_clkgen #(
    .CLKDIV (CLKDIV)
  ) u_clkgen (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (state_q == ST_SHIFT),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

`ifdef SPI_MASTER_MISO_SYNC_EN
  logic [1:0] miso_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso_sync_q <= 2'b00;
    end else begin
      miso_sync_q <= {miso_sync_q[0], miso_pin};
    end
  end

  assign miso_s = miso_sync_q[1];
`else
  assign miso_s = miso_pin;
`endif

  // Transaction sequencer. tmr_q times the SETUP/HOLD/GAP phases; the clkgen
  // ticks pace the SHIFT phase. MOSI is the top bit of frame_q, so shifting
  // on each SCLK fall presents the next bit and leaves zero after the last.
  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    bit_d    = bit_q;
    frame_d  = frame_q;
    rw_d     = rw_q;
    sclk_d   = sclk_q;
    cs_d     = cs_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cap_d    = 1'b0;
    rdata_d  = rdata_q;
    rshift_d = rshift_q;

    // cap_q marks the first high cycle of SCLK; only the data byte's bits
    // (upper half of the bit index) feed the read shift register.
    if (cap_q && bit_q[BW-1]) begin
      rshift_d = {rshift_q[DATA_W-2:0], miso_s};
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SETUP;
          tmr_d   = '0;
          rw_d    = rw;
          frame_d = req_frame;
          cs_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end

      ST_SETUP: begin
        if (tmr_end) begin
          state_d = ST_SHIFT;
          tmr_d   = '0;
          bit_d   = '0;
          sclk_d  = 1'b1;
          cap_d   = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      ST_SHIFT: begin
        if (fall_tick) begin
          sclk_d  = 1'b0;
          frame_d = {frame_q[FRAME_BITS-2:0], 1'b0};
        end
        if (rise_tick) begin
          if (bit_q == BIT_LAST) begin
            state_d = ST_HOLD;
            tmr_d   = '0;
          end else begin
            bit_d  = bit_q + 1'b1;
            sclk_d = 1'b1;
            cap_d  = 1'b1;
          end
        end
      end

      ST_HOLD: begin
        if (tmr_end) begin
          state_d = ST_GAP;
          tmr_d   = '0;
          cs_d    = 1'b1;
          frame_d = '0;
          done_d  = 1'b1;
          if (rw_q == CMD_READ) begin
            rdata_d = rshift_q;
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      ST_GAP: begin
        if (tmr_end) begin
          state_d = ST_IDLE;
          tmr_d   = '0;
          busy_d  = 1'b0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        tmr_d   = '0;
        frame_d = '0;
        sclk_d  = 1'b0;
        cs_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Every output comes straight from a flop; reset abandons any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      tmr_q    <= '0;
      bit_q    <= '0;
      frame_q  <= '0;
      rw_q     <= 1'b0;
      sclk_q   <= 1'b0;
      cs_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cap_q    <= 1'b0;
      rdata_q  <= '0;
      rshift_q <= '0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      bit_q    <= bit_d;
      frame_q  <= frame_d;
      rw_q     <= rw_d;
      sclk_q   <= sclk_d;
      cs_q     <= cs_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cap_q    <= cap_d;
      rdata_q  <= rdata_d;
      rshift_q <= rshift_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rdata    = rdata_q;
  assign sclk_pin = sclk_q;
  assign cs_pin   = cs_q;
  assign mosi_pin = frame_q[FRAME_BITS-1];

endmodule
